shift_add_mul: RTL and testbench

//  Parametrised sequential shift-add multiplier with its control FSM, operand registers and a start/done handshake.

---
 rtl/shift_add_mul_pkg.sv | 26 ++
 rtl/mul_ctrl.sv | 82 ++++++++
 rtl/shift_add_mul.sv | 125 ++++++++++++
 tb/tb_shift_add_mul.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/shift_add_mul_pkg.sv
// ============================================================================
// shift_add_mul_pkg : shared state encoding and sizing helpers for the multiplier
// Revision 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package shift_add_mul_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_INIT = 2'd0,
    ST_EXEC = 2'd1,
    ST_IDLE = 2'd2,
    ST_HALT = 2'd3
  } mul_state_t;

  // Width of a counter that must hold values 0..w inclusive.
  function automatic int count_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mul_ctrl.sv
// ============================================================================
// mul_ctrl : four-state control FSM and processed-bit counter for shift_add_mul
// Revision 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module mul_ctrl
  import shift_add_mul_pkg::*;
#(
  parameter int  WIDTH      = 8,
  parameter int  EARLY_EXIT = 1,
  localparam int CW         = count_width(WIDTH)
) (
  input  logic               clk,
  input  logic               areset,
  input  logic               start,
  input  logic               lsb,
  input  logic               rest_zero,
  output logic [STATE_W-1:0] state,
  output logic [CW-1:0]      count,
  output logic               ready,
  output logic               done,
  output logic               accept,
  output logic               busy,
  output logic               finish
);

  mul_state_t r_state;
  mul_state_t w_next;
  logic       w_last;
  logic       w_exit;

  assign w_last = (count == CW'(WIDTH - 1));
  assign w_exit = (EARLY_EXIT != 0) && rest_zero;

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_state <= ST_INIT;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      count <= '0;
    end else if (accept) begin
      count <= '0;
    end else if (busy) begin
      count <= count + CW'(1);
    end
  end

  // In INIT, lsb/rest_zero describe the incoming operand; otherwise the
  // shifted register, so one decode serves both the accept and step cases.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_INIT: begin
        if (start) begin
          w_next = w_exit ? ST_HALT : (lsb ? ST_EXEC : ST_IDLE);
        end
      end
      ST_EXEC, ST_IDLE: begin
        w_next = (w_last || w_exit) ? ST_HALT : (lsb ? ST_EXEC : ST_IDLE);
      end
      ST_HALT: w_next = ST_INIT;
      default: w_next = ST_INIT;
    endcase
  end

  assign state  = r_state;
  assign ready  = (r_state == ST_INIT);
  assign done   = (r_state == ST_HALT);
  assign busy   = (r_state == ST_EXEC) || (r_state == ST_IDLE);
  assign accept = ready && start;
  assign finish = (w_next == ST_HALT) && (r_state != ST_HALT);

endmodule

`default_nettype wire

// File: rtl/shift_add_mul.sv
// ============================================================================
// shift_add_mul : sequential shift-add multiplier datapath with start/done handshake
// Revision 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module shift_add_mul
  import shift_add_mul_pkg::*;
#(
  parameter int  WIDTH      = 8,
  parameter int  SIGNED     = 0,
  parameter int  EARLY_EXIT = 1,
  localparam int CW         = count_width(WIDTH)
) (
  input  logic                 clk,
  input  logic                 areset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 ready,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic [STATE_W-1:0]   state,
  output logic [CW-1:0]        count
);

  localparam int PW = 2 * WIDTH;

  logic [PW-1:0]    r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [PW-1:0]    r_acc;
  logic             r_neg;

  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic             w_neg;
  logic             w_lsb;
  logic             w_rest_zero;
  logic             w_accept;
  logic             w_busy;
  logic             w_finish;
  logic [PW-1:0]    w_acc_sum;
  logic [PW-1:0]    w_result;

  // Signed mode works on magnitudes; -2^(W-1) negates to itself, which read
  // as unsigned is exactly its magnitude.
  always_comb begin
    w_a_mag = multiplicand;
    w_b_mag = multiplier;
    w_neg   = 1'b0;
    if (SIGNED != 0) begin
      if (multiplicand[WIDTH-1]) w_a_mag = -multiplicand;
      if (multiplier[WIDTH-1])   w_b_mag = -multiplier;
      w_neg = multiplicand[WIDTH-1] ^ multiplier[WIDTH-1];
    end
  end

  assign w_lsb       = ready ? w_b_mag[0] : r_mplier[1];
  assign w_rest_zero = ready ? (w_b_mag == '0) : (r_mplier[WIDTH-1:1] == '0);

  mul_ctrl #(
    .WIDTH      (WIDTH),
    .EARLY_EXIT (EARLY_EXIT)
  ) u_ctrl (
    .clk       (clk),
    .areset    (areset),
    .start     (start),
    .lsb       (w_lsb),
    .rest_zero (w_rest_zero),
    .state     (state),
    .count     (count),
    .ready     (ready),
    .done      (done),
    .accept    (w_accept),
    .busy      (w_busy),
    .finish    (w_finish)
  );

  assign w_acc_sum = r_acc + ((state == ST_EXEC) ? r_mcand : '0);

  // Finishing straight from INIT means a zero multiplier: the result is zero.
  always_comb begin
    w_result = '0;
    if (!ready) begin
      w_result = r_neg ? -w_acc_sum : w_acc_sum;
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_neg    <= 1'b0;
    end else if (w_accept) begin
      r_mcand  <= {{WIDTH{1'b0}}, w_a_mag};
      r_mplier <= w_b_mag;
      r_neg    <= w_neg;
    end else if (w_busy) begin
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_acc <= '0;
    end else if (w_accept) begin
      r_acc <= '0;
    end else if (w_busy) begin
      r_acc <= w_acc_sum;
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      product <= '0;
    end else if (w_finish) begin
      product <= w_result;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_shift_add_mul.sv
// ============================================================================
// tb_shift_add_mul : scoreboard bench over several WIDTH/SIGNED/EARLY_EXIT builds
// Revision 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_shift_add_mul;

  localparam int NCFG   = 6;
  localparam int CFG_W [NCFG] = '{8, 8, 8, 8, 4, 16};
  localparam int CFG_S [NCFG] = '{0, 0, 1, 1, 1, 0};
  localparam int CFG_E [NCFG] = '{0, 1, 0, 1, 1, 1};
  localparam int N_RAND = 400;
  localparam int N_DIR  = 11;
  localparam int DIR_A [N_DIR] = '{13, 255,   0, 1, 7, 7,   3, -128, -3,  127, -1};
  localparam int DIR_B [N_DIR] = '{11, 255, 200, 1, 0, 1, 128, -128,  5, -128, -1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc   = 0;
  int n_cmp = 0;
  int n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    localparam int W  = CFG_W[g];
    localparam int S  = CFG_S[g];
    localparam int E  = CFG_E[g];
    localparam int PW = 2 * W;
    localparam int CW = $clog2(W + 1);

    logic          areset = 1'b1;
    logic          start  = 1'b0;
    logic [W-1:0]  mcand  = '0;
    logic [W-1:0]  mplier = '0;
    logic          ready;
    logic          done;
    logic [PW-1:0] product;
    logic [1:0]    state;
    logic [CW-1:0] count;

    logic [PW-1:0] exp_prod [$];
    int            exp_lat  [$];
    int            exp_cyc  [$];
    logic          hold_v = 1'b0;
    logic [PW-1:0] hold_p = '0;
    logic [PW-1:0] ep;
    int            el;
    int            ec;
    bit            fin = 1'b0;

    shift_add_mul #(
      .WIDTH      (W),
      .SIGNED     (S),
      .EARLY_EXIT (E)
    ) u_dut (
      .clk          (clk),
      .areset       (areset),
      .start        (start),
      .multiplicand (mcand),
      .multiplier   (mplier),
      .ready        (ready),
      .done         (done),
      .product      (product),
      .state        (state),
      .count        (count)
    );

    task automatic chk(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
        n_bad++;
        $display("FAIL cfg%0d (W=%0d S=%0d E=%0d) %s: got %0h expected %0h",
                 g, W, S, E, name, act, exp);
      end
    endtask

    function automatic longint as_int(input logic [W-1:0] v);
      if (S != 0) return longint'($signed(v));
      return longint'(v);
    endfunction

    function automatic logic [PW-1:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b);
      longint p;
      p = as_int(a) * as_int(b);
      return PW'(p);
    endfunction

    function automatic int ref_lat(input logic [W-1:0] b);
      longint m;
      int     p;
      if (E == 0) return W + 1;
      m = as_int(b);
      if (m < 0) m = -m;
      if (m == 0) return 1;
      p = 0;
      for (int i = 0; i < 64; i++) if (m[i]) p = i;
      return p + 2;
    endfunction

    // Called at the negedge before the accepting posedge.
    task automatic push(input logic [W-1:0] a, input logic [W-1:0] b);
      exp_prod.push_back(ref_prod(a, b));
      exp_lat.push_back(ref_lat(b));
      exp_cyc.push_back(cyc + 1);
      hold_v = 1'b0;
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
      int n = 0;
      @(negedge clk);
      while (!ready && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (!ready) begin
        chk("ready_timeout", 0, 1);
        return;
      end
      mcand  = a;
      mplier = b;
      start  = 1'b1;
      push(a, b);
      @(negedge clk);
      start = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
      chk({tag, "_state"},   longint'(state),   0);
      chk({tag, "_ready"},   longint'(ready),   1);
      chk({tag, "_done"},    longint'(done),    0);
      chk({tag, "_product"}, longint'(product), 0);
      chk({tag, "_count"},   longint'(count),   0);
    endtask

    always @(posedge clk) begin
      if (!areset && ready && start) begin
        assert (!$isunknown({mcand, mplier}))
          else $error("cfg%0d: X on operands at accept edge", g);
      end
    end

    always @(negedge clk) begin
      if (!areset) begin
        if (done) begin
          if (exp_prod.size() == 0) begin
            chk("spurious_done", 1, 0);
          end else begin
            ep = exp_prod.pop_front();
            el = exp_lat.pop_front();
            ec = exp_cyc.pop_front();
            chk("product", longint'(product), longint'(ep));
            chk("latency", longint'(cyc - ec + 1), longint'(el));
            hold_v = 1'b1;
            hold_p = ep;
          end
        end else if (hold_v) begin
          chk("product_hold", longint'(product), longint'(hold_p));
        end
      end
    end

    initial begin
      int n;
      repeat (3) @(negedge clk);
      chk_reset_outputs("por");
      areset = 1'b0;
      hold_v = 1'b1;
      hold_p = '0;

      for (int i = 0; i < N_DIR; i++) issue(W'(DIR_A[i]), W'(DIR_B[i]));

      // start held high: whatever sits on the operands while ready is what counts
      start = 1'b1;
      for (int k = 0; k < 5 * (W + 2); k++) begin
        mcand  = W'($urandom);
        mplier = W'($urandom) >> $urandom_range(0, W - 1);
        if (ready) push(mcand, mplier);
        @(negedge clk);
      end
      start = 1'b0;

      // asynchronous reset in the middle of an operation
      issue(W'(5), {1'b0, {(W-1){1'b1}}});
      n = 0;
      while (count != CW'(W / 2) && n < 40) begin
        @(negedge clk);
        n++;
      end
      chk("midop_count_reached", longint'(count), longint'(W / 2));
      areset = 1'b1;
      exp_prod.delete();
      exp_lat.delete();
      exp_cyc.delete();
      #1;
      chk_reset_outputs("midop");
      hold_v = 1'b1;
      hold_p = '0;
      @(negedge clk);
      areset = 1'b0;
      issue(W'(6), W'(7));

      for (int i = 0; i < N_RAND; i++) begin
        issue(W'($urandom), W'($urandom) >> $urandom_range(0, W - 1));
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      for (int k = 0; k < 100 && exp_prod.size() != 0; k++) @(negedge clk);
      chk("drain_empty", longint'(exp_prod.size()), 0);
      fin = 1'b1;
    end
  end

  initial begin
    int k = 0;
    while (!(g_cfg[0].fin && g_cfg[1].fin && g_cfg[2].fin &&
             g_cfg[3].fin && g_cfg[4].fin && g_cfg[5].fin) && k < 90000) begin
      @(posedge clk);
      k++;
    end
    if (!(g_cfg[0].fin && g_cfg[1].fin && g_cfg[2].fin &&
          g_cfg[3].fin && g_cfg[4].fin && g_cfg[5].fin)) begin
      n_cmp++;
      n_bad++;
      $display("FAIL global_timeout: got unfinished drivers after %0d cycles, required all finished", k);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
